// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register family.
package pipe_pkg;

  // Encoding equals the number of entries held, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] ROM_BASE = 32'h0040_0000;
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Handshake FSM for the skid stage: tracks occupancy and steers the datapath loads.
module pipe_skid_ctrl
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   in_valid,
  input  logic   out_ready,
  output state_t state,
  output logic   load_main,
  output logic   load_skid,
  output logic   sel_skid
);

  state_t state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (in_valid) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (in_valid && !out_ready)      state_nxt = ST_FULL;
        else if (!in_valid && out_ready) state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (out_ready) state_nxt = ST_BUSY;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // In FULL nothing is accepted, so a main load there is always the skid-to-main move.
  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    sel_skid  = (state == ST_FULL);
    if (!flush) begin
      case (state)
        ST_EMPTY: load_main = in_valid;
        ST_BUSY: begin
          load_main = in_valid && out_ready;
          load_skid = in_valid && !out_ready;
        end
        ST_FULL:  load_main = out_ready;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer and bubble flush.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int          N            = 32,
  parameter logic [31:0] RESET_VALUE  = ROM_BASE,
  parameter logic [31:0] BUBBLE_VALUE = MIPS_NOP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occupancy
);

  localparam logic [N-1:0] RST_V = N'(RESET_VALUE);
  localparam logic [N-1:0] BUB_V = N'(BUBBLE_VALUE);

  state_t       state;
  logic         load_main;
  logic         load_skid;
  logic         sel_skid;
  logic [N-1:0] main_p1;
  logic [N-1:0] skid_p1;

  pipe_skid_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .state     (state),
    .load_main (load_main),
    .load_skid (load_skid),
    .sel_skid  (sel_skid)
  );

  // Stage boundary: main drives the downstream stage, skid catches the entry stalled by backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_p1 <= RST_V;
      skid_p1 <= BUB_V;
    end else if (flush) begin
      main_p1 <= BUB_V;
      skid_p1 <= BUB_V;
    end else begin
      if (load_main) main_p1 <= sel_skid ? skid_p1 : in_data;
      if (load_skid) skid_p1 <= in_data;
    end
  end

  assign out_data  = main_p1;
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL);
  assign occupancy = state;

endmodule
